// File: rtl/ddr3_rd_pkg.sv
// Shared types and helpers for the DDR3 burst frame reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default geometry localparams, lane-mask helpers.
// The mask helpers work on a MASK_MAX-lane vector so one definition serves
// every DATA_W up to 1024 bits; callers keep only their low BYTES lanes.
package ddr3_rd_pkg;

    localparam int DEF_DATA_W     = 256;
    localparam int DEF_ADDR_W     = 22;
    localparam int DEF_MAX_BURST  = 16;
    localparam int DEF_FIFO_DEPTH = 128;

    localparam int BYTES = DEF_DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int BC_W  = $clog2(DEF_MAX_BURST) + 1;

    // Widest lane mask the helpers can produce (DATA_W = 1024).
    localparam int MASK_MAX = 128;
    localparam logic [MASK_MAX-1:0] MASK_ONE = MASK_MAX'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

    // Lanes at or above the frame's start offset inside the first beat.
    function automatic logic [MASK_MAX-1:0] head_mask(input logic [7:0] off);
        return {MASK_MAX{1'b1}} << off;
    endfunction

    // Lanes below the end offset inside the last beat; an end offset of 0
    // means the frame ends exactly on a beat boundary, so every lane is live.
    function automatic logic [MASK_MAX-1:0] tail_mask(input logic [7:0] end_off);
        if (end_off == 8'd0) begin
            return {MASK_MAX{1'b1}};
        end
        return (MASK_ONE << end_off) - MASK_ONE;
    endfunction

endpackage

// File: rtl/ddr3_rd_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on rd_dat while rd_vld.
// Latency: write to rd_vld is 1 cycle; pop takes effect at the clock edge.
// Backpressure: none internally; the writer must never push when full (asserted).
//
// Ports: wr_en/wr_dat push; rd_en pops the head when rd_vld; used = entries held.
module ddr3_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     ddr3_emif_clk,
    input  logic                     ddr3_emif_rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   used
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_rd;

    assign do_rd  = rd_en && (count != '0);
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign used   = count;

    always_ff @(posedge ddr3_emif_clk) begin
        if (ddr3_emif_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (wr_en ? (PW+1)'(1) : (PW+1)'(0))
                           - (do_rd ? (PW+1)'(1) : (PW+1)'(0));
        end
    end

    // Storage is not reset: the pointers define which entries are live.
    always_ff @(posedge ddr3_emif_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // The reader's credit scheme makes overflow impossible.
    assert property (@(posedge ddr3_emif_clk) disable iff (ddr3_emif_rst)
                     !(wr_en && (count == (PW+1)'(DEPTH))));

endmodule

// File: rtl/ddr3_burst_reader.sv
// Fetches N strided frames from the DDR3 EMIF with multi-beat bursts, tags beats with lane mask/SOF/EOF.
// Latency: start -> first read 2 cycles; rddata_valid -> out_valid 1 cycle.
// Backpressure: reads are issued only while FIFO space covers every beat in flight; out_ready stalls pops.
//
// Ports: ddr3_emif_* = EMIF command/return side; cmd_* = start pulse, frame geometry, busy/done;
//        out_valid/out_ready/out_data = show-ahead FIFO of {data, byte_mask, sof, eof}.
// Option: define DDR3_RD_STATS_EN to add stat_beats (FIFO pushes) and stat_stall (read & !ready cycles).
module ddr3_burst_reader
    import ddr3_rd_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                                  ddr3_emif_clk,
    input  logic                                  ddr3_emif_rst,
    input  logic                                  ddr3_emif_ready,
    output logic                                  ddr3_emif_read,
    output logic [ADDR_W-1:0]                     ddr3_emif_addr,
    output logic [$clog2(MAX_BURST):0]            ddr3_emif_burst_count,
    input  logic [DATA_W-1:0]                     ddr3_emif_read_data,
    input  logic                                  ddr3_emif_rddata_valid,
    input  logic                                  cmd_start,
    input  logic [ADDR_W+$clog2(DATA_W/8)-1:0]    cmd_start_addr,
    input  logic [31:0]                           cmd_frame_num,
    input  logic [31:0]                           cmd_frame_bytes,
    input  logic [31:0]                           cmd_frame_stride,
    output logic                                  cmd_busy,
    output logic                                  cmd_done,
`ifdef DDR3_RD_STATS_EN
    output logic [31:0]                           stat_beats,
    output logic [31:0]                           stat_stall,
`endif
    input  logic                                  out_ready,
    output logic                                  out_valid,
    output logic [DATA_W+DATA_W/8+1:0]            out_data
);

    localparam int N_BYTES = DATA_W / 8;
    localparam int N_OFF_W = $clog2(N_BYTES);
    localparam int N_BC_W  = $clog2(MAX_BURST) + 1;
    localparam int BA_W    = ADDR_W + N_OFF_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W   = DATA_W + N_BYTES + 2;
    localparam int BEAT_W  = 33;

    rd_state_t            state;
    rd_state_t            state_nxt;

    logic [BA_W-1:0]      frame_base;
    logic [BA_W-1:0]      stride_r;
    logic [31:0]          frames_left;
    logic [31:0]          frame_bytes_r;
    logic [ADDR_W-1:0]    issue_addr;
    logic [BEAT_W-1:0]    beats_left;
    logic [BEAT_W-1:0]    beats_per_frame;
    logic [BEAT_W-1:0]    ret_beat;
    logic [N_BYTES-1:0]   head_r;
    logic [N_BYTES-1:0]   tail_r;
    logic [CNT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     fifo_used;
    logic [N_BC_W-1:0]    bc_cur;
    logic [CNT_W:0]       credit;
    logic                 issue_hs;
    logic                 frame_last_cmd;
    logic                 start_acc;

    logic [N_OFF_W-1:0]   setup_off;
    logic [33:0]          setup_span;
    logic [BEAT_W-1:0]    setup_beats;
    logic [N_OFF_W-1:0]   setup_end_off;

    logic                 ret_en;
    logic                 ret_sof;
    logic                 ret_eof;
    logic [N_BYTES-1:0]   ret_mask;
    logic [ENT_W-1:0]     push_dat;

    // Frame geometry. Strides are whole beats, so the start offset (and thus
    // the beat count and masks) is identical for every frame of a command.
    assign setup_off     = frame_base[N_OFF_W-1:0];
    assign setup_span    = 34'(setup_off) + 34'(frame_bytes_r);
    assign setup_beats   = BEAT_W'((setup_span + 34'(N_BYTES - 1)) >> N_OFF_W);
    assign setup_end_off = setup_span[N_OFF_W-1:0];

    assign bc_cur = (beats_left >= BEAT_W'(MAX_BURST)) ? N_BC_W'(MAX_BURST)
                                                        : N_BC_W'(beats_left);
    assign frame_last_cmd = (beats_left == BEAT_W'(bc_cur));

    // Space that is neither occupied nor promised to beats still in flight.
    // Returns move a beat from "in flight" to "held", so credit only grows
    // while a command waits, which keeps read/addr/burst_count stable.
    assign credit = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, fifo_used} - {1'b0, outstanding};

    assign start_acc = (state == ST_IDLE) && cmd_start;
    assign issue_hs  = ddr3_emif_read && ddr3_emif_ready;

    always_comb begin
        state_nxt      = state;
        ddr3_emif_read = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if ((frames_left == 32'd0) || (frame_bytes_r == 32'd0)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ddr3_emif_read = (credit >= (CNT_W+1)'(bc_cur));
                if (ddr3_emif_read && ddr3_emif_ready && frame_last_cmd) begin
                    state_nxt = (frames_left == 32'd1) ? ST_DRAIN : ST_SETUP;
                end
            end
            ST_DRAIN: begin
                if (outstanding == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ddr3_emif_clk) begin
        if (ddr3_emif_rst) begin
            state           <= ST_IDLE;
            frame_base      <= '0;
            stride_r        <= '0;
            frames_left     <= '0;
            frame_bytes_r   <= '0;
            issue_addr      <= '0;
            beats_left      <= '0;
            beats_per_frame <= '0;
            ret_beat        <= '0;
            head_r          <= '0;
            tail_r          <= '0;
            outstanding     <= '0;
        end else begin
            state <= state_nxt;

            if (start_acc) begin
                frame_base    <= cmd_start_addr;
                stride_r      <= BA_W'(cmd_frame_stride);
                frames_left   <= cmd_frame_num;
                frame_bytes_r <= cmd_frame_bytes;
                ret_beat      <= '0;
            end

            if (state == ST_SETUP) begin
                issue_addr      <= frame_base[BA_W-1:N_OFF_W];
                beats_left      <= setup_beats;
                beats_per_frame <= setup_beats;
                head_r          <= N_BYTES'(head_mask(8'(setup_off)));
                tail_r          <= N_BYTES'(tail_mask(8'(setup_end_off)));
            end

            if (issue_hs) begin
                issue_addr <= issue_addr + ADDR_W'(bc_cur);
                beats_left <= beats_left - BEAT_W'(bc_cur);
                if (frame_last_cmd) begin
                    frames_left <= frames_left - 32'd1;
                    frame_base  <= frame_base + stride_r;
                end
            end

            outstanding <= outstanding
                         + (issue_hs ? CNT_W'(bc_cur) : CNT_W'(0))
                         - (ret_en   ? CNT_W'(1)      : CNT_W'(0));

            if (ret_en) begin
                ret_beat <= ret_eof ? '0 : ret_beat + BEAT_W'(1);
            end
        end
    end

    // EMIF returns in command order, so a running beat index within the
    // frame is enough to recover SOF/EOF and the lane mask.
    assign ret_en   = ddr3_emif_rddata_valid && (state != ST_IDLE);
    assign ret_sof  = (ret_beat == '0);
    assign ret_eof  = (ret_beat == beats_per_frame - BEAT_W'(1));
    assign ret_mask = (ret_sof ? head_r : {N_BYTES{1'b1}})
                    & (ret_eof ? tail_r : {N_BYTES{1'b1}});
    assign push_dat = {ddr3_emif_read_data, ret_mask, ret_sof, ret_eof};

    ddr3_rd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ddr3_emif_clk (ddr3_emif_clk),
        .ddr3_emif_rst (ddr3_emif_rst),
        .wr_en         (ret_en),
        .wr_dat        (push_dat),
        .rd_en         (out_ready),
        .rd_vld        (out_valid),
        .rd_dat        (out_data),
        .used          (fifo_used)
    );

    assign ddr3_emif_addr        = issue_addr;
    assign ddr3_emif_burst_count = bc_cur;
    assign cmd_busy              = (state != ST_IDLE);
    assign cmd_done              = (state == ST_DONE);

`ifdef DDR3_RD_STATS_EN
    always_ff @(posedge ddr3_emif_clk) begin
        if (ddr3_emif_rst || start_acc) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else begin
            if (ret_en && (stat_beats != '1)) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if (ddr3_emif_read && !ddr3_emif_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
